// File: rtl/boot_sequencer_if.sv
// Shared boot bus between the boot sequencer, the three image EEPROMs and the
// three lookup-table SRAMs. The sequencer is the master.
interface boot_sequencer_if;
  logic [7:0]  rom_data;
  logic [1:0]  rom_sel;
  logic [16:0] addr;
  logic [7:0]  data;
  logic        mlu_slice_n_we;
  logic        mlu_lookahead_n_we;
  logic        control_n_we;
  logic        n_booted;
  logic        boot_err;

  modport master (
    input  rom_data,
    output rom_sel, addr, data,
    output mlu_slice_n_we, mlu_lookahead_n_we, control_n_we,
    output n_booted, boot_err
  );

  modport slave (
    output rom_data,
    input  rom_sel, addr, data,
    input  mlu_slice_n_we, mlu_lookahead_n_we, control_n_we,
    input  n_booted, boot_err
  );
endinterface

// File: rtl/boot_sequencer.sv
// Power-on loader: copies slice, lookahead and control images from EEPROM into SRAM.
// Optional per-image trailing checksum verification is enabled with BOOT_CHECKSUM_EN.
module boot_sequencer #(
  parameter int SLICE_WORDS     = 65536,
  parameter int LOOKAHEAD_WORDS = 4096,
  parameter int CONTROL_WORDS   = 4096,
  parameter int ROM_WAIT        = 2
) (
  input  logic             clk_i,
  input  logic             n_rst_i,
  boot_sequencer_if.master bus
);

  localparam int WAIT_W = (ROM_WAIT > 1) ? $clog2(ROM_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ROM_WAIT - 1);
  localparam logic [16:0] SLICE_LAST     = 17'(SLICE_WORDS - 1);
  localparam logic [16:0] LOOKAHEAD_LAST = 17'(LOOKAHEAD_WORDS - 1);
  localparam logic [16:0] CONTROL_LAST   = 17'(CONTROL_WORDS - 1);

  localparam logic [1:0] PH_SLICE     = 2'd0;
  localparam logic [1:0] PH_LOOKAHEAD = 2'd1;
  localparam logic [1:0] PH_CONTROL   = 2'd2;
  localparam logic [1:0] PH_NONE      = 2'd3;

  typedef enum logic [2:0] {
    S_SETUP,
    S_CAPTURE,
    S_STROBE,
    S_HOLD,
    S_DONE
`ifdef BOOT_CHECKSUM_EN
    ,
    S_CHECK,
    S_ERROR
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [16:0]       addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [2:0]        n_we_q, n_we_d;
  logic              n_booted_q, n_booted_d;
  logic [16:0]       last_addr;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       chk_q, chk_d;
  logic       boot_err_q, boot_err_d;
  logic [7:0] chk_sum;

  assign chk_sum = sum_q + bus.rom_data;
`endif

  always_comb begin
    case (phase_q)
      PH_SLICE:     last_addr = SLICE_LAST;
      PH_LOOKAHEAD: last_addr = LOOKAHEAD_LAST;
      default:      last_addr = CONTROL_LAST;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q    <= S_SETUP;
      phase_q    <= PH_SLICE;
      wait_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      n_we_q     <= 3'b111;
      n_booted_q <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
      sum_q      <= '0;
      chk_q      <= 1'b0;
      boot_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      n_we_q     <= n_we_d;
      n_booted_q <= n_booted_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q      <= sum_d;
      chk_q      <= chk_d;
      boot_err_q <= boot_err_d;
`endif
    end
  end

  // Next state; the phase change on the last word preempts any address increment.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d   = sum_q;
    chk_d   = chk_q;
`endif
    case (state_q)
      S_SETUP: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
`ifdef BOOT_CHECKSUM_EN
          state_d = chk_q ? S_CHECK : S_CAPTURE;
`else
          state_d = S_CAPTURE;
`endif
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        state_d = S_STROBE;
`ifdef BOOT_CHECKSUM_EN
        sum_d   = chk_sum;
`endif
      end
      S_STROBE: state_d = S_HOLD;
      S_HOLD: begin
        state_d = S_SETUP;
        if (addr_q == last_addr) begin
`ifdef BOOT_CHECKSUM_EN
          chk_d  = 1'b1;
          addr_d = addr_q + 1'b1;
`else
          addr_d  = '0;
          phase_d = (phase_q == PH_CONTROL) ? PH_NONE : phase_q + 1'b1;
          if (phase_q == PH_CONTROL) state_d = S_DONE;
`endif
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHECK: begin
        chk_d  = 1'b0;
        sum_d  = '0;
        addr_d = '0;
        if (chk_sum == 8'h00) begin
          phase_d = (phase_q == PH_CONTROL) ? PH_NONE : phase_q + 1'b1;
          state_d = (phase_q == PH_CONTROL) ? S_DONE : S_SETUP;
        end else begin
          phase_d = PH_NONE;
          state_d = S_ERROR;
        end
      end
      S_ERROR: state_d = S_ERROR;
`endif
      S_DONE:  state_d = S_DONE;
      default: state_d = S_DONE;
    endcase
  end

  // Outputs are decoded from the next state so every strobe leaves a flop.
  always_comb begin
    data_d     = data_q;
    n_we_d     = 3'b111;
    n_booted_d = (state_d != S_DONE);
    if (state_q == S_CAPTURE) data_d = bus.rom_data;
    if (state_d == S_STROBE) begin
      case (phase_d)
        PH_SLICE:     n_we_d = 3'b110;
        PH_LOOKAHEAD: n_we_d = 3'b101;
        PH_CONTROL:   n_we_d = 3'b011;
        default:      n_we_d = 3'b111;
      endcase
    end
    if (state_d == S_DONE) data_d = '0;
`ifdef BOOT_CHECKSUM_EN
    boot_err_d = (state_d == S_ERROR);
    if (state_d == S_ERROR) data_d = '0;
`endif
  end

  assign bus.rom_sel            = phase_q;
  assign bus.addr               = addr_q;
  assign bus.data               = data_q;
  assign bus.mlu_slice_n_we     = n_we_q[0];
  assign bus.mlu_lookahead_n_we = n_we_q[1];
  assign bus.control_n_we       = n_we_q[2];
  assign bus.n_booted           = n_booted_q;
`ifdef BOOT_CHECKSUM_EN
  assign bus.boot_err           = boot_err_q;
`else
  assign bus.boot_err           = 1'b0;
`endif

endmodule
